// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_ctrl
// Brief    : UART transmit control; latches a byte and steps the TX bit-select
//            mux through start, 8 data bits (LSB first) and stop.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic [7:0] data_reg,
    output logic [3:0] sel,
    output logic       busy,
    output logic       done
);

    localparam int                 c_CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    localparam logic [3:0] c_SEL_START = 4'd0;
    localparam logic [3:0] c_SEL_D0    = 4'd1;
    localparam logic [3:0] c_SEL_STOP  = 4'd9;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic               w_wrap;

    assign w_wrap = (r_cnt == c_CNT_MAX);

    // sel/busy/done are updated together with the state so every output is a flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            data_reg  <= 8'h00;
            sel       <= c_SEL_STOP;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (tx_start) begin
                        data_reg <= tx_data;
                        r_cnt    <= '0;
                        r_state  <= c_START;
                        sel      <= c_SEL_START;
                        busy     <= 1'b1;
                    end
                end
                c_START: begin
                    if (w_wrap) begin
                        r_cnt     <= '0;
                        r_bit_idx <= 3'd0;
                        r_state   <= c_DATA;
                        sel       <= c_SEL_D0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_DATA: begin
                    if (w_wrap) begin
                        r_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= c_STOP;
                            sel     <= c_SEL_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            sel       <= 4'(r_bit_idx) + 4'd2;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_STOP: begin
                    if (w_wrap) begin
                        r_cnt   <= '0;
                        r_state <= c_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    sel     <= c_SEL_STOP;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_ctrl
// Brief    : Directed self-checking bench for uart_tx_ctrl (CLKS_PER_BIT 4 and 868).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] data_reg;
    logic [3:0] sel;
    logic       busy;
    logic       done;

    logic       tx_start_b = 1'b0;
    logic [7:0] tx_data_b = 8'h00;
    logic [7:0] data_reg_b;
    logic [3:0] sel_b;
    logic       busy_b;
    logic       done_b;

    int checks = 0;
    int failures = 0;

    uart_tx_ctrl #(.CLKS_PER_BIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .tx_start(tx_start), .tx_data(tx_data),
        .data_reg(data_reg), .sel(sel), .busy(busy), .done(done)
    );

    uart_tx_ctrl #(.CLKS_PER_BIT(868)) dut_big (
        .clk(clk), .rst_n(rst_n), .tx_start(tx_start_b), .tx_data(tx_data_b),
        .data_reg(data_reg_b), .sel(sel_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    // Downstream mux: 0 -> 1'b0, 1..8 -> data bit, 9 -> 1'b1, others -> 0
    function automatic logic line_of(input logic [3:0] s, input logic [7:0] d);
        if (s == 4'd0)                  return 1'b0;
        else if (s >= 4'd1 && s <= 4'd8) return d[s - 4'd1];
        else if (s == 4'd9)             return 1'b1;
        else                            return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends one byte from idle and checks every cycle of the frame (CLKS_PER_BIT = 4)
    task automatic run_frame(input string tag, input logic [7:0] d, input logic [9:0] line_exp);
        int es;
        tx_data  = d;
        tx_start = 1'b1;
        for (int k = 1; k <= 41; k++) begin
            @(posedge clk); #1;
            if (k == 1) tx_start = 1'b0;
            es = (k <= 40) ? (k - 1) / 4 : 9;
            chk($sformatf("%s_sel_k%0d", tag, k), 32'(sel), 32'(es));
            chk($sformatf("%s_busy_k%0d", tag, k), 32'(busy), 32'(k <= 40));
            chk($sformatf("%s_done_k%0d", tag, k), 32'(done), 32'(k == 41));
            chk($sformatf("%s_data_k%0d", tag, k), 32'(data_reg), 32'(d));
            chk($sformatf("%s_line_k%0d", tag, k), 32'(line_of(sel, data_reg)), 32'(line_exp[es]));
        end
    endtask

    initial begin
        int es, j, max_cnt;
        logic [7:0] dexp;
        logic [9:0] lexp;

        // Asynchronous reset between edges
        #7 rst_n = 1'b0;
        #1;
        chk("rst_sel", 32'(sel), 32'd9);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_data", 32'(data_reg), 32'h00);
        chk("rst_big_sel", 32'(sel_b), 32'd9);
        chk("rst_big_busy", 32'(busy_b), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_sel", 32'(sel), 32'd9);

        // Single byte A5: line 0,1,0,1,0,0,1,0,1,1
        run_frame("a5", 8'hA5, 10'b1101001010);

        // Busy ignore: 3C, then FF request at T+10
        tx_data  = 8'h3C;
        tx_start = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk); #1;
            if (k == 1)  tx_start = 1'b0;
            if (k == 10) begin tx_data = 8'hFF; tx_start = 1'b1; end
            if (k == 11) tx_start = 1'b0;
            es = (k <= 40) ? (k - 1) / 4 : 9;
            chk($sformatf("ign_sel_k%0d", k), 32'(sel), 32'(es));
            chk($sformatf("ign_busy_k%0d", k), 32'(busy), 32'(k <= 40));
            chk($sformatf("ign_done_k%0d", k), 32'(done), 32'(k == 41));
            chk($sformatf("ign_data_k%0d", k), 32'(data_reg), 32'h3C);
            chk($sformatf("ign_line_k%0d", k), 32'(line_of(sel, data_reg)), 32'(es == 9 ? 1 : (10'b1001111000 >> es) & 1));
        end

        // Back-to-back: tx_start held, 01 then 80 accepted in the done cycle
        tx_data  = 8'h01;
        tx_start = 1'b1;
        for (int k = 1; k <= 83; k++) begin
            @(posedge clk); #1;
            if (k == 20) tx_data = 8'h80;
            if (k == 42) tx_start = 1'b0;
            j    = (k <= 41) ? k : k - 41;
            dexp = (k <= 41) ? 8'h01 : 8'h80;
            lexp = (k <= 41) ? 10'b1000000010 : 10'b1100000000;
            es   = (j <= 40) ? (j - 1) / 4 : 9;
            chk($sformatf("b2b_sel_k%0d", k), 32'(sel), 32'(es));
            chk($sformatf("b2b_busy_k%0d", k), 32'(busy), 32'(j <= 40));
            chk($sformatf("b2b_done_k%0d", k), 32'(done), 32'(j == 41));
            chk($sformatf("b2b_data_k%0d", k), 32'(data_reg), 32'(dexp));
            chk($sformatf("b2b_line_k%0d", k), 32'(line_of(sel, data_reg)), 32'(lexp[es]));
        end

        // Mid-frame reset at T+17
        tx_data  = 8'h55;
        tx_start = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk); #1;
            if (k == 1) tx_start = 1'b0;
            chk($sformatf("mid_sel_k%0d", k), 32'(sel), 32'((k - 1) / 4));
            chk($sformatf("mid_line_k%0d", k), 32'(line_of(sel, data_reg)), 32'((10'b1010101010 >> ((k - 1) / 4)) & 1));
        end
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_sel", 32'(sel), 32'd9);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_data", 32'(data_reg), 32'h00);
        @(posedge clk); @(posedge clk); #1;
        chk("mid_hold_sel", 32'(sel), 32'd9);
        rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            chk($sformatf("mid_after_done_%0d", k), 32'(done), 32'd0);
            chk($sformatf("mid_after_sel_%0d", k), 32'(sel), 32'd9);
        end
        run_frame("c3", 8'hC3, 10'b1110000110);

        // Large parameter, byte 00
        max_cnt = 0;
        tx_data_b  = 8'h00;
        tx_start_b = 1'b1;
        for (int k = 1; k <= 8682; k++) begin
            @(posedge clk); #1;
            if (k == 1) tx_start_b = 1'b0;
            if (int'(dut_big.r_cnt) > max_cnt) max_cnt = int'(dut_big.r_cnt);
            if (k <= 8680 && (((k - 1) % 868) == 0 || (k % 868) == 0))
                chk($sformatf("big_sel_k%0d", k), 32'(sel_b), 32'((k - 1) / 868));
            if (k == 8680) begin
                chk("big_done_8680", 32'(done_b), 32'd0);
                chk("big_busy_8680", 32'(busy_b), 32'd1);
            end
            if (k == 8681) begin
                chk("big_done_8681", 32'(done_b), 32'd1);
                chk("big_busy_8681", 32'(busy_b), 32'd0);
                chk("big_sel_8681", 32'(sel_b), 32'd9);
            end
            if (k == 8682) chk("big_done_8682", 32'(done_b), 32'd0);
        end
        chk("big_cnt_max", 32'(max_cnt), 32'd867);
        chk("big_data", 32'(data_reg_b), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
